regfile_write_arbiter: RTL
==========================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter IALU_WORD_WIDTH, default 16, register data width.
REQ-002 SHALL have parameter REG_IDX_WIDTH, default 4, register index width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, the number of blocked cycles that triggers a forced drain.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in_wb_act_write, input, 1 bit: writeback stage requests a register write.
REQ-007 SHALL have ports in_wb_res (input, IALU_WORD_WIDTH) and in_wb_res_reg_idx (input, REG_IDX_WIDTH): writeback data and destination register.
REQ-008 SHALL have port in_ld_valid, input, 1 bit: load-return requester offers data.
REQ-009 SHALL have ports in_ld_data (input, IALU_WORD_WIDTH) and in_ld_reg_idx (input, REG_IDX_WIDTH): load data and destination register.
REQ-010 SHALL have port out_ld_ready, output, 1 bit: a load is accepted when in_ld_valid and out_ld_ready are both high.
REQ-011 SHALL have ports out_rf_we (output, 1), out_rf_data (output, IALU_WORD_WIDTH) and out_rf_idx (output, REG_IDX_WIDTH): the single register-file write port.
REQ-012 SHALL have port out_busy_mask, output, 2^REG_IDX_WIDTH bits: bit i set while any buffered load targets register i.
REQ-013 SHALL have port out_stall_pipe, output, 1 bit: freezes the upstream pipeline.

Function
REQ-014 SHALL buffer accepted loads in a 2-entry FIFO (head, tail, count 0..2); out_ld_ready = (count != 2).
REQ-015 SHALL always route accepted loads through the FIFO; the earliest write of an accepted load is the cycle after acceptance (no bypass).
REQ-016 SHALL, in state NORMAL, grant writeback when in_wb_act_write=1: out_rf_we=1, data and index taken from the wb inputs combinationally in the same cycle.
REQ-017 SHALL, in state NORMAL with in_wb_act_write=0 and count>0, pop the head: out_rf_we=1, data and index taken from the head entry.
REQ-018 SHALL drive out_rf_we=0 when no request is granted; out_rf_data and out_rf_idx are then 0.
REQ-019 SHALL allow a push and a pop in the same cycle; count is unchanged and the FIFO order is preserved.
REQ-020 SHALL compute out_busy_mask from the valid FIFO entries only, combinationally; two entries with the same index set one bit.
REQ-021 SHALL NOT reorder: a wb write to a register whose busy bit is set is performed as granted; interlocking is the decode stage's job, using out_busy_mask.
REQ-022 SHALL wrap the head and tail pointers modulo 2.

Reset
REQ-023 SHALL, while reset is high, clear count, pointers, FIFO contents, the starvation counter and the state (to NORMAL).
REQ-024 SHALL drive these values during and after reset: out_rf_we=0, out_rf_data=0, out_rf_idx=0, out_busy_mask=0, out_stall_pipe=0, out_ld_ready=1.
REQ-025 SHALL discard buffered loads when reset is asserted mid-operation; they are not written.

Configuration
REQ-026 SHALL compile in starvation control only when macro REGFILE_WRITE_ARBITER_STARVE_EN is defined.
REQ-027 With the macro defined:
- A counter increments each NORMAL cycle where count>0 and wb is granted.
- The counter clears on any pop.
- When the counter reaches STARVE_LIMIT, the state becomes DRAIN on the next edge.
REQ-028 In DRAIN:
- out_stall_pipe=1, in_wb_act_write is ignored, and the head is popped.
- The block returns to NORMAL next cycle with the counter cleared.
- Upstream SHALL hold the wb inputs stable while stalled.
REQ-029 Without the macro, out_stall_pipe is tied 0, there is no counter and no DRAIN state, and the FIFO may starve indefinitely.

Verification
REQ-030 Reset, idle -> out_rf_we=0, out_ld_ready=1, out_busy_mask=0.
REQ-031 wb write of idx 3, data 0x1234, no loads -> same cycle out_rf_we=1, out_rf_idx=3, out_rf_data=0x1234.
REQ-032 Loads to idx 5 and idx 7 on consecutive cycles while wb is held active -> count=2, out_ld_ready=0, out_busy_mask=0x00A0; after wb drops, the loads are written in order 5 then 7 and the mask returns to 0.
REQ-033 count=1, and in the same cycle a push of idx 2 plus a pop -> count stays 1, out_ld_ready stays 1, the head becomes idx 2.
REQ-034 With the macro defined, 1 load pending and wb active continuously -> after 4 blocked cycles out_stall_pipe=1 for exactly 1 cycle with the load written that cycle; without the macro, out_stall_pipe stays 0.
REQ-035 Reset pulsed with count=2 -> out_busy_mask=0, out_ld_ready=1 immediately, and no write of the discarded entries occurs.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of writeback, load-return and register-file write signals around regfile_write_arbiter.
// The master modport is the upstream pipeline/testbench side; slave is the arbiter.
interface regfile_write_arbiter_if #(
  parameter int IALU_WORD_WIDTH = 16,
  parameter int REG_IDX_WIDTH   = 4
);
  logic                            in_wb_act_write;
  logic [IALU_WORD_WIDTH-1:0]      in_wb_res;
  logic [REG_IDX_WIDTH-1:0]        in_wb_res_reg_idx;
  logic                            in_ld_valid;
  logic [IALU_WORD_WIDTH-1:0]      in_ld_data;
  logic [REG_IDX_WIDTH-1:0]        in_ld_reg_idx;
  logic                            out_ld_ready;
  logic                            out_rf_we;
  logic [IALU_WORD_WIDTH-1:0]      out_rf_data;
  logic [REG_IDX_WIDTH-1:0]        out_rf_idx;
  logic [(1<<REG_IDX_WIDTH)-1:0]   out_busy_mask;
  logic                            out_stall_pipe;

  modport master (
    output in_wb_act_write, in_wb_res, in_wb_res_reg_idx,
    output in_ld_valid, in_ld_data, in_ld_reg_idx,
    input  out_ld_ready, out_rf_we, out_rf_data, out_rf_idx,
    input  out_busy_mask, out_stall_pipe
  );

  modport slave (
    input  in_wb_act_write, in_wb_res, in_wb_res_reg_idx,
    input  in_ld_valid, in_ld_data, in_ld_reg_idx,
    output out_ld_ready, out_rf_we, out_rf_data, out_rf_idx,
    output out_busy_mask, out_stall_pipe
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Single-port register-file write arbiter: writeback has priority, loads queue in a 2-entry FIFO.
// Define REGFILE_WRITE_ARBITER_STARVE_EN to add the starvation counter and DRAIN state.
module regfile_write_arbiter #(
  parameter int IALU_WORD_WIDTH = 16,
  parameter int REG_IDX_WIDTH   = 4,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  regfile_write_arbiter_if.slave bus
);
  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  logic [IALU_WORD_WIDTH-1:0] fifo_data [2];
  logic [REG_IDX_WIDTH-1:0]   fifo_idx  [2];
  logic                       head;
  logic                       tail;
  logic [1:0]                 count;
  logic                       push;
  logic                       pop;
  logic                       wb_grant;
  logic                       drain;

  assign bus.out_ld_ready = (count != 2'd2);
  assign push             = bus.in_ld_valid && bus.out_ld_ready;

  // Grant is gated by reset so the write port stays quiet while reset is held.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wb_grant = 1'b0;
    pop      = 1'b0;
    if (!reset) begin
      if (drain)                    pop      = (count != 2'd0);
      else if (bus.in_wb_act_write) wb_grant = 1'b1;
      else if (count != 2'd0)       pop      = 1'b1;
    end
  end

  always_comb begin
    bus.out_rf_we   = 1'b0;
    bus.out_rf_data = '0;
    bus.out_rf_idx  = '0;
    if (wb_grant) begin
      bus.out_rf_we   = 1'b1;
      bus.out_rf_data = bus.in_wb_res;
      bus.out_rf_idx  = bus.in_wb_res_reg_idx;
    end else if (pop) begin
      bus.out_rf_we   = 1'b1;
      bus.out_rf_data = fifo_data[head];
      bus.out_rf_idx  = fifo_idx[head];
    end
  end

  always_comb begin
    bus.out_busy_mask = '0;
    if (count != 2'd0) bus.out_busy_mask[fifo_idx[head]]  = 1'b1;
    if (count == 2'd2) bus.out_busy_mask[fifo_idx[~head]] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
      // NOTE: the FIFO storage is explicitly cleared so discarded loads leave no trace after reset.
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_idx[i]  <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (push) begin
        fifo_data[tail] <= bus.in_ld_data;
        fifo_idx[tail]  <= bus.in_ld_reg_idx;
        tail            <= ~tail;
      end
      if (pop) head <= ~head;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef REGFILE_WRITE_ARBITER_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {NORMAL, DRAIN} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= NORMAL;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_cnt_next;
    end
  end

  // The cycle that brings the counter to STARVE_LIMIT also moves the FSM into DRAIN.
  always_comb begin
    state_next      = state;
    starve_cnt_next = starve_cnt;
    case (state)
      NORMAL: begin
        if (pop) begin
          starve_cnt_next = '0;
        end else if (wb_grant && count != 2'd0) begin
          starve_cnt_next = starve_cnt + CNT_W'(1);
          if (starve_cnt_next == CNT_W'(STARVE_LIMIT)) state_next = DRAIN;
        end
      end
      DRAIN: begin
        state_next      = NORMAL;
        starve_cnt_next = '0;
      end
      default: state_next = NORMAL;
    endcase
  end

  assign drain              = (state == DRAIN);
  assign bus.out_stall_pipe = drain;
`else
  assign drain              = 1'b0;
  assign bus.out_stall_pipe = 1'b0;
`endif
endmodule
